rainbow_scroller: RTL and testbench

Pixel-pipeline stage that drives the rainbow colour ROM and consumes its output. It takes VGA pixel coordinates from the sync generator and computes a 32-band horizontal rainbow with a per-frame animated phase. It presents the band address to the ROM, then re-aligns video_on and the syncs with the ROM's 2-cycle read latency to produce the final 12-bit RGB. The ROM is a sibling instance wired at the top level.

---
 rtl/rainbow_pkg.sv | 22 ++
 rtl/rainbow_phase_ctrl.sv | 71 +++++++
 rtl/rainbow_scroller.sv | 92 +++++++++
 tb/tb_rainbow_scroller.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rainbow_pkg.sv
// Shared constants and types for the rainbow scroller pixel stage.
//   ROM_BASE / NUM_BANDS : colour ROM window (addresses 24..55, 32 bands)
//   mode_e               : animation mode encodings
//   bounce_e             : bounce direction state
package rainbow_pkg;

  localparam int unsigned ROM_BASE  = 24;
  localparam int unsigned NUM_BANDS = 32;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'd0,
    MODE_INC    = 2'd1,
    MODE_DEC    = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } bounce_e;

endpackage

// File: rtl/rainbow_phase_ctrl.sv
// Per-frame phase animation for the rainbow scroller.
//   clk, reset : clock, synchronous active-high reset
//   p_tick     : pixel-enable strobe
//   x, y       : current pixel coordinates (frame tick at x==0, y==V_ACTIVE)
//   mode       : animation mode, sampled only when a step occurs
//   phase      : 5-bit band offset, changes only on frame ticks
module rainbow_phase_ctrl
  import rainbow_pkg::*;
#(
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned FRAMES_PER_STEP = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p_tick,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [1:0] mode,
  output logic [4:0] phase
);

  bounce_e    state_q, state_d;
  logic [4:0] phase_q, phase_d;
  logic [7:0] cnt_q, cnt_d;
  logic       frame_tick;

  assign frame_tick = p_tick && (x == '0) && (y == 10'(V_ACTIVE));
  assign phase      = phase_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= UP;
      phase_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  // Bounce state only advances in bounce mode, so it is retained across
  // excursions into other modes and resumes where it left off.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (frame_tick) begin
      if (cnt_q == 8'(FRAMES_PER_STEP - 1)) begin
        cnt_d = '0;
        case (mode)
          MODE_INC: phase_d = phase_q + 5'd1;
          MODE_DEC: phase_d = phase_q - 5'd1;
          MODE_BOUNCE: begin
            if (state_q == UP) begin
              phase_d = phase_q + 5'd1;
              if (phase_d == 5'd31) state_d = DOWN;
            end else begin
              phase_d = phase_q - 5'd1;
              if (phase_d == 5'd0) state_d = UP;
            end
          end
          default: phase_d = phase_q;
        endcase
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: rtl/rainbow_scroller.sv
// Rainbow pixel stage: band addressing for the colour ROM and re-alignment
// of video_on / syncs with the ROM's 2-cycle read latency.
//   clk, reset           : clock, synchronous active-high reset
//   p_tick, x, y         : pixel strobe and coordinates from the sync generator
//   video_on             : active-area flag
//   hsync_in, vsync_in   : raw syncs
//   mode                 : animation mode (hold / +1 / -1 / bounce)
//   rom_addr             : band address to the ROM (24..55)
//   rom_data             : ROM output, valid 2 clk after rom_addr
//   rgb                  : final 12-bit colour, 3 clk after the sampling edge
//   hsync_out, vsync_out : syncs aligned with rgb
module rainbow_scroller
  import rainbow_pkg::*;
#(
  parameter int unsigned BAND_W          = 20,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned FRAMES_PER_STEP = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [1:0]  mode,
  output logic [6:0]  rom_addr,
  input  logic [11:0] rom_data,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out
);

  logic [4:0] phase;
  logic [4:0] band_reg;
  logic [9:0] pix_cnt;
  logic [2:0] vid_pipe, hs_pipe, vs_pipe;

  rainbow_phase_ctrl #(
    .V_ACTIVE       (V_ACTIVE),
    .FRAMES_PER_STEP(FRAMES_PER_STEP)
  ) u_phase (
    .clk   (clk),
    .reset (reset),
    .p_tick(p_tick),
    .x     (x),
    .y     (y),
    .mode  (mode),
    .phase (phase)
  );

  // band_reg doubles as the line band counter; pix_cnt is the position of
  // the current pixel inside its band, so BAND_W=1 steps on every pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      band_reg <= '0;
      pix_cnt  <= '0;
    end else if (p_tick) begin
      if (x == '0) begin
        band_reg <= phase;
        pix_cnt  <= '0;
      end else if (pix_cnt == 10'(BAND_W - 1)) begin
        band_reg <= band_reg + 5'd1;
        pix_cnt  <= '0;
      end else begin
        pix_cnt <= pix_cnt + 10'd1;
      end
    end
  end

  assign rom_addr = 7'(ROM_BASE) + {2'b00, band_reg};

  always_ff @(posedge clk) begin
    if (reset) begin
      vid_pipe  <= '0;
      hs_pipe   <= '0;
      vs_pipe   <= '0;
      rgb       <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      vid_pipe  <= {vid_pipe[1:0], video_on};
      hs_pipe   <= {hs_pipe[1:0], hsync_in};
      vs_pipe   <= {vs_pipe[1:0], vsync_in};
      rgb       <= vid_pipe[2] ? rom_data : '0;
      hsync_out <= hs_pipe[2];
      vsync_out <= vs_pipe[2];
    end
  end

endmodule

// File: tb/tb_rainbow_scroller.sv
module tb_rainbow_scroller;

  localparam int BAND_W   = 20;
  localparam int V_ACTIVE = 480;
  localparam int FPS      = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        p_tick = 1'b0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic        video_on = 1'b0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data = '0;
  logic [11:0] rgb;
  logic        hsync_out;
  logic        vsync_out;
  logic [6:0]  rom_q = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rainbow_scroller #(
    .BAND_W         (BAND_W),
    .V_ACTIVE       (V_ACTIVE),
    .FRAMES_PER_STEP(FPS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .p_tick   (p_tick),
    .x        (x),
    .y        (y),
    .video_on (video_on),
    .hsync_in (hsync_in),
    .vsync_in (vsync_in),
    .mode     (mode),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rgb      (rgb),
    .hsync_out(hsync_out),
    .vsync_out(vsync_out)
  );

  function automatic logic [11:0] rom_fn(input int a);
    logic [6:0] v;
    v = 7'(a);
    if (v == 7'd24) return 12'hF00;
    if (v == 7'd55) return 12'h00F;
    return {v[3:0], v[6:3], v[3:0] ^ 4'hA};
  endfunction

  // Colour ROM: address register then data register (2 clk latency).
  always @(posedge clk) begin
    rom_q    <= rom_addr;
    rom_data <= rom_fn(int'(rom_q));
  end

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { bit vid; bit hs; bit vs; int addr; } ent_t;
  ent_t hist[3];
  int  m_phase, m_fc, m_line_phase, m_addr, e_rgb, e_hs, e_vs;
  bit  m_down;
  bit  model_ok = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_fc = 0; m_down = 0; m_line_phase = 0; m_addr = 24;
      e_rgb = 0; e_hs = 0; e_vs = 0;
      for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0, 24};
      model_ok = 1;
    end else begin
      e_rgb = hist[2].vid ? int'(rom_fn(hist[2].addr)) : 0;
      e_hs  = hist[2].hs;
      e_vs  = hist[2].vs;
      if (p_tick) begin
        if (x == 0) m_line_phase = m_phase;
        m_addr = 24 + (m_line_phase + int'(x) / BAND_W) % 32;
        if (x == 0 && int'(y) == V_ACTIVE) begin
          m_fc++;
          if (m_fc == FPS) begin
            m_fc = 0;
            case (mode)
              2'd1: m_phase = (m_phase + 1) % 32;
              2'd2: m_phase = (m_phase + 31) % 32;
              2'd3: begin
                if (!m_down) begin
                  m_phase = (m_phase + 1) % 32;
                  if (m_phase == 31) m_down = 1;
                end else begin
                  m_phase = (m_phase + 31) % 32;
                  if (m_phase == 0) m_down = 0;
                end
              end
              default: ;
            endcase
          end
        end
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = '{video_on, hsync_in, vsync_in, m_addr};
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("model_rom_addr", int'(rom_addr), m_addr);
      chk("model_rgb", int'(rgb), e_rgb);
      chk("model_hsync", int'(hsync_out), e_hs);
      chk("model_vsync", int'(vsync_out), e_vs);
    end
  end

  // ---------------- stimulus ----------------
  task automatic pixel(input int px, input int py, input bit vid, input bit hs,
                       input bit vs, input int gap);
    @(negedge clk);
    p_tick = 1'b1; x = 10'(px); y = 10'(py);
    video_on = vid; hsync_in = hs; vsync_in = vs;
    @(negedge clk);
    p_tick = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic frame_tick();
    pixel(0, V_ACTIVE, 0, 0, 0, 1);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame_tick();
  endtask

  task automatic line_start(input string name, input int exp_addr);
    pixel(0, 5, 1, 0, 0, 2);
    chk(name, int'(rom_addr), exp_addr);
  endtask

  task automatic rand_line(input int len);
    for (int i = 0; i < len; i++)
      pixel(i, $urandom_range(0, 479), ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
            $urandom_range(0, 2));
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1; p_tick = 1'b0;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state and flush.
    do_reset(2);
    chk("reset_rom_addr", int'(rom_addr), 24);
    chk("reset_rgb", int'(rgb), 0);
    chk("reset_hsync", int'(hsync_out), 0);
    chk("reset_vsync", int'(vsync_out), 0);
    video_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset_rgb", int'(rgb), 0);
    end

    // Mode 0, phase 0, p_tick every 4 clk across a full line.
    mode = 2'd0;
    pixel(0, 0, 1, 0, 0, 2);
    chk("x0_addr", int'(rom_addr), 24);
    @(negedge clk);
    chk("x0_rgb", int'(rgb), 12'hF00);
    for (int i = 1; i < 640; i++) begin
      pixel(i, 0, 1, 0, 0, 2);
      if (i == 19) chk("x19_addr", int'(rom_addr), 24);
      if (i == 20) chk("x20_addr", int'(rom_addr), 25);
      if (i == 639) chk("x639_addr", int'(rom_addr), 55);
    end
    @(negedge clk);
    chk("x639_rgb", int'(rgb), 12'h00F);

    // Blanking and hsync alignment at x=100.
    for (int i = 0; i < 101; i++) pixel(i, 1, (i != 100), (i == 100), 0, 2);
    chk("x100_addr", int'(rom_addr), 29);
    @(negedge clk);
    chk("x100_rgb_blank", int'(rgb), 0);
    chk("x100_hsync", int'(hsync_out), 1);

    // Mode 1 stepping.
    mode = 2'd1;
    frames(2);
    line_start("inc_one_step", 25);
    frames(62);
    line_start("inc_wrap", 24);

    // Mode 2 from phase 0.
    mode = 2'd2;
    frames(2);
    line_start("dec_wrap", 55);
    mode = 2'd1;
    frames(2);
    line_start("back_to_zero", 24);

    // Bounce.
    mode = 2'd3;
    frames(2 * 31);
    line_start("bounce_top", 55);
    frames(2);
    line_start("bounce_30", 54);
    frames(2);
    line_start("bounce_29", 53);
    mode = 2'd0;
    frames(5);
    line_start("hold_29", 53);
    mode = 2'd3;
    frames(2);
    line_start("bounce_resume_28", 52);

    // Randomized traffic, with one idle reset and one full-width line.
    for (int it = 0; it < 40; it++) begin
      mode = 2'($urandom_range(0, 3));
      frames($urandom_range(0, 5));
      if (it == 20) do_reset($urandom_range(1, 3));
      rand_line((it == 30) ? 640 : $urandom_range(1, 80));
    end
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
